// File: rtl/load_store_unit.sv
// load_store_unit: CPU-side initiator for the MemoryController request/ready interface.
// Defining LSU_TIMEOUT_EN adds a BUSY-cycle watchdog that aborts a stuck access.
module load_store_unit #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 17
`ifdef LSU_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  stall,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic                  resp_valid,
   output logic                  fault,
   output logic [1:0]            fault_cause,
   output logic                  MemWrite,
   output logic [2:0]            SizeCtr,
   output logic [ADDR_WIDTH-1:0] addr,
   output logic [DATA_WIDTH-1:0] WriteData,
   input  logic [DATA_WIDTH-1:0] ReadData,
   input  logic                  MemReady
);

   localparam logic [2:0] F3_B      = 3'b000;
   localparam logic [2:0] F3_H      = 3'b001;
   localparam logic [2:0] F3_W      = 3'b010;
   localparam logic [2:0] F3_BU     = 3'b100;
   localparam logic [2:0] F3_HU     = 3'b101;
   localparam logic [2:0] SIZE_NONE = 3'b111;

   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_mem_write,  w_mem_write_nxt;
   logic [2:0]            r_size,       w_size_nxt;
   logic [ADDR_WIDTH-1:0] r_addr,       w_addr_nxt;
   logic [DATA_WIDTH-1:0] r_wdata,      w_wdata_nxt;
   logic [DATA_WIDTH-1:0] r_rdata,      w_rdata_nxt;
   logic                  r_resp_valid, w_resp_valid_nxt;
   logic                  r_fault,      w_fault_nxt;
   logic [1:0]            r_cause,      w_cause_nxt;
   logic                  w_stall;
   logic                  w_illegal;
   logic                  w_misalign;

`ifdef LSU_TIMEOUT_EN
   localparam logic [1:0] CAUSE_TIMEOUT = 2'b11;
   localparam logic [7:0] CNT_LAST      = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] r_busy_cnt, w_busy_cnt_nxt;
`endif

   // Stores may only use b/h/w; the unsigned variants are load-only.
   always_comb begin
      w_illegal = 1'b1;
      case (req_funct3)
         F3_B, F3_H, F3_W: w_illegal = 1'b0;
         F3_BU, F3_HU:     w_illegal = req_write;
         default:          w_illegal = 1'b1;
      endcase
   end

   always_comb begin
      w_misalign = 1'b0;
      case (req_funct3)
         F3_W:        w_misalign = |req_addr[1:0];
         F3_H, F3_HU: w_misalign = req_addr[0];
         default:     w_misalign = 1'b0;
      endcase
   end

   // Next-state and registered-output values; r_mem_write/r_size double as the latched request.
   always_comb begin
      w_state_nxt      = r_state;
      w_mem_write_nxt  = 1'b0;
      w_size_nxt       = SIZE_NONE;
      w_addr_nxt       = r_addr;
      w_wdata_nxt      = r_wdata;
      w_rdata_nxt      = r_rdata;
      w_resp_valid_nxt = 1'b0;
      w_fault_nxt      = 1'b0;
      w_cause_nxt      = CAUSE_NONE;
      w_stall          = 1'b0;
`ifdef LSU_TIMEOUT_EN
      w_busy_cnt_nxt   = r_busy_cnt;
`endif
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (w_illegal) begin
                  w_fault_nxt = 1'b1;
                  w_cause_nxt = CAUSE_ILLEGAL;
               end else if (w_misalign) begin
                  w_fault_nxt = 1'b1;
                  w_cause_nxt = CAUSE_MISALIGN;
               end else begin
                  w_state_nxt     = S_BUSY;
                  w_mem_write_nxt = req_write;
                  w_size_nxt      = req_funct3;
                  w_addr_nxt      = req_addr;
                  w_wdata_nxt     = req_wdata;
                  w_stall         = 1'b1;
`ifdef LSU_TIMEOUT_EN
                  w_busy_cnt_nxt  = 8'd0;
`endif
               end
            end
         end
         S_BUSY: begin
            w_stall         = 1'b1;
            w_mem_write_nxt = r_mem_write;
            w_size_nxt      = r_size;
`ifdef LSU_TIMEOUT_EN
            w_busy_cnt_nxt  = r_busy_cnt + 8'd1;
`endif
            if (MemReady) begin
               w_state_nxt      = S_RESP;
               w_mem_write_nxt  = 1'b0;
               w_size_nxt       = SIZE_NONE;
               w_resp_valid_nxt = 1'b1;
               if (!r_mem_write) begin
                  w_rdata_nxt = ReadData;
               end
`ifdef LSU_TIMEOUT_EN
            end else if (r_busy_cnt == CNT_LAST) begin
               w_state_nxt     = S_RESP;
               w_mem_write_nxt = 1'b0;
               w_size_nxt      = SIZE_NONE;
               w_fault_nxt     = 1'b1;
               w_cause_nxt     = CAUSE_TIMEOUT;
               w_rdata_nxt     = '0;
`endif
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_mem_write  <= 1'b0;
         r_size       <= SIZE_NONE;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_rdata      <= '0;
         r_resp_valid <= 1'b0;
         r_fault      <= 1'b0;
         r_cause      <= CAUSE_NONE;
      end else begin
         r_state      <= w_state_nxt;
         r_mem_write  <= w_mem_write_nxt;
         r_size       <= w_size_nxt;
         r_addr       <= w_addr_nxt;
         r_wdata      <= w_wdata_nxt;
         r_rdata      <= w_rdata_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_fault      <= w_fault_nxt;
         r_cause      <= w_cause_nxt;
      end
   end

`ifdef LSU_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy_cnt <= 8'd0;
      end else begin
         r_busy_cnt <= w_busy_cnt_nxt;
      end
   end
`endif

   // Stall is combinational so the MEM stage freezes in the accepting cycle itself.
   assign stall       = w_stall & ~reset;
   assign rdata       = r_rdata;
   assign resp_valid  = r_resp_valid;
   assign fault       = r_fault;
   assign fault_cause = r_cause;
   assign MemWrite    = r_mem_write;
   assign SizeCtr     = r_size;
   assign addr        = r_addr;
   assign WriteData   = r_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized transactions against a transaction-level model.
module tb_load_store_unit;

`ifdef LSU_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   localparam int TO_N = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [16:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        resp_valid;
   logic        fault;
   logic [1:0]  fault_cause;
   logic        MemWrite;
   logic [2:0]  SizeCtr;
   logic [16:0] addr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        MemReady;

   int          n_chk  = 0;
   int          n_fail = 0;
   logic [31:0] exp_rdata = 32'h0;

   load_store_unit #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(17)
`ifdef LSU_TIMEOUT_EN
      ,
      .TIMEOUT_CYCLES(TO_N)
`endif
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .stall(stall), .rdata(rdata), .resp_valid(resp_valid),
      .fault(fault), .fault_cause(fault_cause),
      .MemWrite(MemWrite), .SizeCtr(SizeCtr), .addr(addr), .WriteData(WriteData),
      .ReadData(ReadData), .MemReady(MemReady)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit is_illegal(input bit w, input logic [2:0] f3);
      bit legal_any  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      bit legal_load = (f3 == 3'd4) || (f3 == 3'd5);
      return !(legal_any || (!w && legal_load));
   endfunction

   function automatic bit is_misaligned(input logic [2:0] f3, input logic [16:0] a);
      int bytes;
      bytes = (f3[1:0] == 2'd2) ? 4 : (f3[1:0] == 2'd1) ? 2 : 1;
      return (int'(a) % bytes) != 0;
   endfunction

   // Idle-cycle outputs expected once a transaction has fully retired.
   task automatic chk_quiet(input string tag);
      chk({tag, "_resp"},  32'(resp_valid), 32'd0);
      chk({tag, "_fault"}, 32'(fault), 32'd0);
      chk({tag, "_mw"},    32'(MemWrite), 32'd0);
      chk({tag, "_size"},  32'(SizeCtr), 32'd7);
      chk({tag, "_rdata"}, rdata, exp_rdata);
   endtask

   // Entered and left at posedge+1 with the DUT idle.
   task automatic run_txn(input bit w, input logic [2:0] f3, input logic [16:0] a,
                          input logic [31:0] wd, input int wait_n, input logic [31:0] rd);
      bit ill, mis, timed_out;
      int busy_n;
      ill = is_illegal(w, f3);
      mis = is_misaligned(f3, a);
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      MemReady   = 1'($urandom_range(0, 1));
      ReadData   = $urandom;
      #1;
      chk("stall_req", 32'(stall), 32'(!(ill || mis)));
      @(posedge clk); #1;
      if (ill || mis) begin
         chk("flt_fault", 32'(fault), 32'd1);
         chk("flt_cause", 32'(fault_cause), ill ? 32'd2 : 32'd1);
         chk("flt_resp",  32'(resp_valid), 32'd0);
         chk("flt_mw",    32'(MemWrite), 32'd0);
         chk("flt_size",  32'(SizeCtr), 32'd7);
         req_valid = 1'b0;
         #1;
         chk("flt_stall", 32'(stall), 32'd0);
      end else begin
         timed_out = TO_EN && (wait_n >= TO_N);
         busy_n    = timed_out ? TO_N : wait_n + 1;
         for (int k = 0; k < busy_n; k++) begin
            chk("busy_mw",    32'(MemWrite), 32'(w));
            chk("busy_size",  32'(SizeCtr), 32'(f3));
            chk("busy_addr",  32'(addr), 32'(a));
            chk("busy_wdata", WriteData, wd);
            chk("busy_resp",  32'(resp_valid), 32'd0);
            chk("busy_fault", 32'(fault), 32'd0);
            chk("busy_rdata", rdata, exp_rdata);
            req_write  = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = 17'($urandom);
            req_wdata  = $urandom;
            MemReady   = (k == wait_n);
            ReadData   = (k == wait_n) ? rd : $urandom;
            #1;
            chk("busy_stall", 32'(stall), 32'd1);
            @(posedge clk); #1;
         end
         if (timed_out) begin
            exp_rdata = 32'h0;
            chk("to_fault", 32'(fault), 32'd1);
            chk("to_cause", 32'(fault_cause), 32'd3);
            chk("to_resp",  32'(resp_valid), 32'd0);
         end else begin
            if (!w) exp_rdata = rd;
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_fault", 32'(fault), 32'd0);
         end
         chk("resp_rdata", rdata, exp_rdata);
         chk("resp_mw",    32'(MemWrite), 32'd0);
         chk("resp_size",  32'(SizeCtr), 32'd7);
         MemReady = 1'($urandom_range(0, 1));
         #1;
         chk("resp_stall", 32'(stall), 32'd0);
         req_valid = 1'b0;
      end
      MemReady = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk_quiet("idle");
   endtask

   initial begin
      bit          w;
      logic [2:0]  f3;
      logic [16:0] a;

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
      req_addr = '0; req_wdata = '0; ReadData = '0; MemReady = 1'b0;
      #2;
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_addr",  32'(addr), 32'd0);
      chk("rst_wdata", WriteData, 32'd0);
      chk_quiet("rst");
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      run_txn(1'b0, 3'b010, 17'h10000, 32'h0,        0, 32'hDEADBEEF);
      chk("lw_rdata", rdata, 32'hDEADBEEF);
      run_txn(1'b1, 3'b000, 17'h10003, 32'h000000A5, 3, 32'h12345678);
      run_txn(1'b0, 3'b010, 17'h10002, 32'h0,        0, 32'h0);
      run_txn(1'b1, 3'b100, 17'h10001, 32'h0,        0, 32'h0);
      run_txn(1'b0, 3'b101, 17'h10001, 32'h0,        0, 32'h0);
      run_txn(1'b0, 3'b101, 17'h1FFFE, 32'h0,        1, 32'h0000FFFF);
      run_txn(1'b0, 3'b011, 17'h00000, 32'h0,        0, 32'h0);
      run_txn(1'b0, 3'b000, 17'h00007, 32'h0,        TO_N - 1, 32'hCAFEF00D);
      run_txn(1'b0, 3'b010, 17'h00040, 32'h0,        70, 32'h0BADC0DE);

      // Asynchronous reset in the middle of a store's BUSY phase.
      run_txn(1'b0, 3'b010, 17'h00100, 32'h0, 0, 32'h55AA55AA);
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 17'h10004; req_wdata = 32'h13579BDF; MemReady = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rb_mw", 32'(MemWrite), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("ra_mw",    32'(MemWrite), 32'd0);
      chk("ra_size",  32'(SizeCtr), 32'd7);
      chk("ra_stall", 32'(stall), 32'd0);
      chk("ra_rdata", rdata, 32'd0);
      exp_rdata = 32'h0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      chk_quiet("post_rst");
      run_txn(1'b0, 3'b001, 17'h00202, 32'h0, 2, 32'hFFFF8001);

      for (int i = 0; i < 150; i++) begin
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
         a  = 17'($urandom);
         if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
         run_txn(w, f3, a, $urandom, $urandom_range(0, TO_N + 3), $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
